// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple-carry segment built from 1-bit full-adder cells.
// Also exposes the carry into the segment MSB so the top segment can form signed overflow.
module adder_seg #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o,
  output logic           cmsb_o
);

  logic [SEG:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < SEG; i++) begin : gen_bit
    assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[SEG];
  assign cmsb_o = carry[SEG-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: one WIDTH/STAGES-bit carry segment per stage, registered carries,
// valid/ready handshake with a global stall, and a two's-complement overflow flag.
module adder_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : gen_chk_div
    $error("adder_pipe: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end
  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH) begin : gen_chk_range
    $error("adder_pipe: need WIDTH >= 2 and 1 <= STAGES <= WIDTH");
  end

  logic              en;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic              ovf_q;
  logic [WIDTH-1:0]  b_ent;
  logic              cin_ent;

  // Per-stage register outputs. w_s holds the not-yet-added A segments in its low bits and the
  // finished sum segments in its high bits; it rotates down by SEG each stage.
  logic [WIDTH-1:0]  w_s [STAGES];
  logic [WIDTH-1:0]  b_s [STAGES];
  logic [STAGES-1:0] c_s;
  logic [STAGES-1:0] seg_cout;
  logic [STAGES-1:0] seg_cmsb;

  assign en        = !out_valid | out_ready;
  assign in_ready  = en;
  assign b_ent     = sub ? ~b : b;
  assign cin_ent   = sub | cin;

  always_comb begin
    v_d = (v_q << 1) | STAGES'(in_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else if (en) begin
      v_q <= v_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
    logic             ci;
    logic [SEG-1:0]   seg_sum;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;

    if (k == 0) begin : gen_head
      assign wa = a;
      assign wb = b_ent;
      assign ci = cin_ent;
    end else begin : gen_body
      assign wa = w_s[k-1];
      assign wb = b_s[k-1];
      assign ci = c_s[k-1];
    end

    adder_seg #(
      .SEG (SEG)
    ) u_seg (
      .a_i    (wa[SEG-1:0]),
      .b_i    (wb[SEG-1:0]),
      .cin_i  (ci),
      .sum_o  (seg_sum),
      .cout_o (seg_cout[k]),
      .cmsb_o (seg_cmsb[k])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        w_q <= '0;
        b_q <= '0;
        c_q <= 1'b0;
      end else if (en) begin
        w_q <= (wa >> SEG) | (WIDTH'(seg_sum) << (WIDTH - SEG));
        b_q <= wb >> SEG;
        c_q <= seg_cout[k];
      end
    end

    assign w_s[k] = w_q;
    assign b_s[k] = b_q;
    assign c_s[k] = c_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= seg_cmsb[STAGES-1] ^ seg_cout[STAGES-1];
    end
  end

  // Final-stage B skew and lower-segment MSB carries have no consumer.
  logic unused_sink;
  assign unused_sink = ^{b_s[STAGES-1], seg_cmsb};

  assign out_valid = v_q[STAGES-1];
  assign sum       = w_s[STAGES-1];
  assign cout      = c_s[STAGES-1];
  assign ovf       = ovf_q;

endmodule
